// File: rtl/paddle_ctrl.sv
// paddle_ctrl: Pong paddle with synchronised buttons, accelerate/cruise/brake velocity FSM and edge clamping.
// Defining PADDLE_AUTO_EN adds i_auto/i_target_x so the paddle can steer itself toward a target x.
module paddle_ctrl #(
    parameter int COORD_W  = 12,
    parameter int H_WIDTH  = 40,
    parameter int H_HEIGHT = 8,
    parameter int IX       = 320,
    parameter int IY       = 440,
    parameter int D_WIDTH  = 640,
    parameter int MAX_SPD  = 4,
    parameter int ACC_DIV  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ani_stb,
    input  logic               i_animate,
    input  logic               i_left_btn,
    input  logic               i_right_btn,
    input  logic               i_recentre,
`ifdef PADDLE_AUTO_EN
    input  logic               i_auto,
    input  logic [COORD_W-1:0] i_target_x,
`endif
    output logic [COORD_W-1:0] o_x1,
    output logic [COORD_W-1:0] o_x2,
    output logic [COORD_W-1:0] o_y1,
    output logic [COORD_W-1:0] o_y2,
    output logic [7:0]         o_vel,
    output logic               o_at_edge
);
    localparam int AW = (ACC_DIV > 1) ? $clog2(ACC_DIV) : 1;
    localparam logic [AW-1:0] ACC_LAST = AW'(ACC_DIV - 1);
    localparam logic [6:0] SPD_MAX = 7'(MAX_SPD);
    localparam logic [COORD_W-1:0] X_MIN = COORD_W'(H_WIDTH);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(D_WIDTH - 1 - H_WIDTH);
    localparam logic [COORD_W-1:0] X_INIT = COORD_W'(IX);
    localparam logic signed [COORD_W:0] X_LO = (COORD_W+1)'(H_WIDTH);
    localparam logic signed [COORD_W:0] X_HI = (COORD_W+1)'(D_WIDTH - 1 - H_WIDTH);

    typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, BRAKE} state_t;

    state_t state, nst;
    logic [6:0] spd, spd_n;
    logic neg, neg_n;
    logic [AW-1:0] acc, acc_n;
    logic [COORD_W-1:0] x, x_cl;
    logic [7:0] vel, vel_n;
    logic at_edge;
    logic [1:0] l_sync, r_sync;
    logic right, left, fwd, step, clamp_lo, clamp_hi, clamp;
    logic signed [COORD_W:0] x_nxt;

    always_ff @(posedge i_clk) begin
        l_sync <= i_rst ? 2'b00 : {l_sync[0], i_left_btn};
        r_sync <= i_rst ? 2'b00 : {r_sync[0], i_right_btn};
    end

`ifdef PADDLE_AUTO_EN
    localparam logic [COORD_W:0] SPD_EXT = (COORD_W+1)'(MAX_SPD);
    logic [COORD_W:0] tx, xe;
    assign tx    = {1'b0, i_target_x};
    assign xe    = {1'b0, x};
    assign right = i_auto ? (tx > xe + SPD_EXT) : (r_sync[1] & ~l_sync[1]);
    assign left  = i_auto ? (tx + SPD_EXT < xe) : (l_sync[1] & ~r_sync[1]);
`else
    assign right = r_sync[1] & ~l_sync[1];
    assign left  = l_sync[1] & ~r_sync[1];
`endif

    assign fwd  = neg ? left : right;
    assign step = i_ani_stb & i_animate;

    always_ff @(posedge i_clk) begin
        at_edge <= 1'b0;
        if (i_rst || i_recentre) begin
            state <= IDLE;
            spd   <= 7'd0;
            neg   <= 1'b0;
            acc   <= '0;
            x     <= X_INIT;
            vel   <= 8'd0;
        end else if (step) begin
            state   <= clamp ? IDLE : nst;
            spd     <= clamp ? 7'd0 : spd_n;
            neg     <= neg_n;
            acc     <= acc_n;
            x       <= x_cl;
            vel     <= clamp ? 8'd0 : vel_n;
            at_edge <= clamp;
        end
    end

    always_comb begin
        nst   = state;
        spd_n = spd;
        neg_n = neg;
        acc_n = acc;
        case (state)
            IDLE: begin
                nst   = (right | left) ? ((SPD_MAX <= 7'd1) ? CRUISE : ACCEL) : IDLE;
                spd_n = (right | left) ? 7'd1 : 7'd0;
                neg_n = (right | left) ? left : neg;
                acc_n = '0;
            end
            ACCEL: begin
                if (fwd) begin
                    spd_n = (acc == ACC_LAST) ? spd + 7'd1 : spd;
                    acc_n = (acc == ACC_LAST) ? '0 : acc + 1'b1;
                    nst   = (spd_n >= SPD_MAX) ? CRUISE : ACCEL;
                end else begin
                    spd_n = spd - 7'd1;
                    nst   = (spd_n == 7'd0) ? IDLE : BRAKE;
                end
            end
            CRUISE: begin
                spd_n = fwd ? spd : spd - 7'd1;
                nst   = fwd ? CRUISE : ((spd_n == 7'd0) ? IDLE : BRAKE);
            end
            default: begin
                spd_n = spd - 7'd1;
                nst   = (spd_n == 7'd0) ? IDLE : BRAKE;
            end
        endcase
    end

    // Move uses the freshly computed speed; sign-extended so the left clamp sees negatives.
    always_comb begin
        vel_n    = neg_n ? (8'd0 - {1'b0, spd_n}) : {1'b0, spd_n};
        x_nxt    = $signed({1'b0, x}) + $signed({{(COORD_W-7){vel_n[7]}}, vel_n});
        clamp_lo = x_nxt < X_LO;
        clamp_hi = x_nxt > X_HI;
        clamp    = clamp_lo | clamp_hi;
        x_cl     = clamp_lo ? X_MIN : clamp_hi ? X_MAX : x_nxt[COORD_W-1:0];
    end

    assign o_x1      = x - X_MIN;
    assign o_x2      = x + X_MIN;
    assign o_y1      = COORD_W'(IY - H_HEIGHT);
    assign o_y2      = COORD_W'(IY + H_HEIGHT);
    assign o_vel     = vel;
    assign o_at_edge = at_edge;
endmodule
